// File: rtl/garota_mr_if.sv
// Monitor tap bundle: CPU/DMA/interrupt observations in, violation reset and attestation log out.
interface garota_mr_if #(
  parameter int NREGIONS = 2
);
  logic [15:0]         pc;
  logic                data_wr;
  logic [15:0]         data_addr;
  logic [15:0]         dma_addr;
  logic                dma_en;
  logic                irq;
  logic                gie;
  logic                reset;
  logic [NREGIONS+3:0] viol_cause;
  logic [7:0]          viol_count;

  modport master (
    output pc, data_wr, data_addr, dma_addr, dma_en, irq, gie,
    input  reset, viol_cause, viol_count
  );

  modport slave (
    input  pc, data_wr, data_addr, dma_addr, dma_en, irq, gie,
    output reset, viol_cause, viol_count
  );
endinterface

// File: rtl/garota_mr.sv
// Multi-region TCB/peripheral write monitor with stretched violation reset and sticky cause log.
// Optional GAROTA_GIE_LOCK_EN: flag interrupts enabled inside the TCB after its entry instruction.
module garota_mr #(
  parameter int                     NREGIONS    = 2,
  parameter logic [16*NREGIONS-1:0] REGION_BASE = {16'h0090, 16'h0080},
  parameter logic [16*NREGIONS-1:0] REGION_SIZE = {16'h0010, 16'h0010},
  parameter logic [15:0]            TCB_BASE    = 16'hA000,
  parameter logic [15:0]            TCB_SIZE    = 16'h4000,
  parameter int                     RESET_HOLD  = 4
) (
  input  logic         clk,
  input  logic         rst,
  garota_mr_if.slave   bus
);

  localparam int            CW        = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam int            NC        = NREGIONS + 4;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(RESET_HOLD - 1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Ranges are compared in 17 bits so base+size never wraps past 16'hFFFF.
  function automatic logic in_range(input logic [15:0] addr,
                                    input logic [15:0] base,
                                    input logic [15:0] size);
    logic [16:0] lo;
    logic [16:0] hi;
    logic [16:0] a;
    lo = {1'b0, base};
    hi = lo + {1'b0, size};
    a  = {1'b0, addr};
    in_range = (size != 16'h0000) && (a >= lo) && (a < hi);
  endfunction

  state_t          state_r;
  state_t          state_next_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_next_s;
  logic            reset_r;
  logic            prev_in_tcb_r;
  logic [NC-1:0]   cause_r;
  logic [7:0]      count_r;

  logic            in_tcb_s;
  logic [NREGIONS-1:0] v_reg_s;
  logic            v_irq_s;
  logic            v_dma_s;
  logic            v_entry_s;
  logic            v_gie_s;
  logic [NC-1:0]   cause_s;
  logic            any_viol_s;
  logic            count_inc_s;

  assign in_tcb_s = in_range(bus.pc, TCB_BASE, TCB_SIZE);

  // Per-region write checks; DMA is untrusted regardless of pc.
  always_comb begin
    v_reg_s = '0;
    for (int i = 0; i < NREGIONS; i++) begin
      v_reg_s[i] = (bus.data_wr && !in_tcb_s &&
                    in_range(bus.data_addr, REGION_BASE[16*i +: 16], REGION_SIZE[16*i +: 16])) ||
                   (bus.dma_en &&
                    in_range(bus.dma_addr, REGION_BASE[16*i +: 16], REGION_SIZE[16*i +: 16]));
    end
  end

  assign v_irq_s   = bus.irq && in_tcb_s;
  assign v_dma_s   = bus.dma_en && in_tcb_s;
  assign v_entry_s = in_tcb_s && !prev_in_tcb_r && (bus.pc != TCB_BASE);

`ifdef GAROTA_GIE_LOCK_EN
  assign v_gie_s = bus.gie && in_tcb_s && prev_in_tcb_r;
`else
  logic unused_gie_s;
  assign unused_gie_s = bus.gie;
  assign v_gie_s      = 1'b0;
`endif

  assign cause_s    = {v_gie_s, v_entry_s, v_dma_s, v_irq_s, v_reg_s};
  assign any_viol_s = |cause_s;

  // Episode FSM: one count per reset episode, HOLD never reloads its counter.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    count_inc_s  = 1'b0;
    case (state_r)
      RUN: begin
        if (any_viol_s) begin
          state_next_s = HOLD;
          cnt_next_s   = HOLD_LOAD;
          count_inc_s  = 1'b1;
        end else begin
          state_next_s = RUN;
          cnt_next_s   = CNT_ZERO;
        end
      end
      HOLD: begin
        if (cnt_r == CNT_ZERO) begin
          state_next_s = RUN;
          cnt_next_s   = CNT_ZERO;
        end else begin
          state_next_s = HOLD;
          cnt_next_s   = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_next_s = RUN;
        cnt_next_s   = CNT_ZERO;
      end
    endcase
  end

  // State, reset output and attestation log registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= RUN;
      cnt_r         <= CNT_ZERO;
      reset_r       <= 1'b0;
      prev_in_tcb_r <= 1'b0;
      cause_r       <= '0;
      count_r       <= 8'h00;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      reset_r <= (state_next_s == HOLD);
      // Cleared across the whole episode so re-entry after release must hit TCB_BASE.
      if ((state_r == HOLD) || (state_next_s == HOLD)) begin
        prev_in_tcb_r <= 1'b0;
      end else begin
        prev_in_tcb_r <= in_tcb_s;
      end
      cause_r <= cause_r | cause_s;
      if (count_inc_s && (count_r != 8'hFF)) begin
        count_r <= count_r + 8'h01;
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign bus.reset      = reset_r;
  assign bus.viol_cause = cause_r;
  assign bus.viol_count = count_r;

endmodule

// File: tb/tb_garota_mr.sv
// Directed bench for garota_mr: vector table plus multi-cycle HOLD, rst and saturation sequences.
module tb_garota_mr;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  garota_mr_if #(.NREGIONS(2)) bus0 ();
  garota_mr_if #(.NREGIONS(2)) bus1 ();

  assign bus1.pc        = bus0.pc;
  assign bus1.data_wr   = bus0.data_wr;
  assign bus1.data_addr = bus0.data_addr;
  assign bus1.dma_addr  = bus0.dma_addr;
  assign bus1.dma_en    = bus0.dma_en;
  assign bus1.irq       = bus0.irq;
  assign bus1.gie       = bus0.gie;

  garota_mr dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  // Same monitor with region 0 disabled by a zero size.
  garota_mr #(
    .REGION_SIZE ({16'h0010, 16'h0000})
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  typedef struct {
    logic [15:0] pre_pc;
    logic [15:0] pc;
    logic        wr;
    logic [15:0] daddr;
    logic        dma;
    logic [15:0] maddr;
    logic        irq;
    logic        gie;
    logic        exp_reset;
    logic [5:0]  exp_cause;
  } vec_t;

  vec_t vecs[16];

`ifdef GAROTA_GIE_LOCK_EN
  localparam logic       GIE_RST   = 1'b1;
  localparam logic [5:0] GIE_CAUSE = 6'b100000;
`else
  localparam logic       GIE_RST   = 1'b0;
  localparam logic [5:0] GIE_CAUSE = 6'b000000;
`endif

  function automatic vec_t mk(input logic [15:0] pre_pc, input logic [15:0] pc,
                              input logic wr, input logic [15:0] daddr,
                              input logic dma, input logic [15:0] maddr,
                              input logic irq, input logic gie,
                              input logic exp_reset, input logic [5:0] exp_cause);
    vec_t v;
    v.pre_pc = pre_pc; v.pc = pc; v.wr = wr; v.daddr = daddr;
    v.dma = dma; v.maddr = maddr; v.irq = irq; v.gie = gie;
    v.exp_reset = exp_reset; v.exp_cause = exp_cause;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] pc, input logic wr, input logic [15:0] daddr,
                       input logic dma, input logic [15:0] maddr, input logic irq,
                       input logic gie);
    bus0.pc = pc; bus0.data_wr = wr; bus0.data_addr = daddr;
    bus0.dma_en = dma; bus0.dma_addr = maddr; bus0.irq = irq; bus0.gie = gie;
  endtask

  task automatic idle();
    drive(16'h4000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic do_rst();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic check_out(input string nm, input logic r, input logic [5:0] c,
                           input logic [7:0] n);
    check({nm, "_reset"}, {31'd0, bus0.reset}, {31'd0, r});
    check({nm, "_cause"}, {26'd0, bus0.viol_cause}, {26'd0, c});
    check({nm, "_count"}, {24'd0, bus0.viol_count}, {24'd0, n});
  endtask

  initial begin
    //              pre_pc    pc        wr    daddr     dma   maddr     irq   gie   rst   cause
    vecs[0]  = mk(16'h4000, 16'h4000, 1'b1, 16'h0084, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 6'b000001);
    vecs[1]  = mk(16'h4000, 16'h4000, 1'b1, 16'h0090, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 6'b000010);
    vecs[2]  = mk(16'hA000, 16'hA010, 1'b1, 16'h0088, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 6'b000000);
    vecs[3]  = mk(16'h4000, 16'h4000, 1'b1, 16'h00A0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 6'b000000);
    vecs[4]  = mk(16'h4000, 16'h4000, 1'b1, 16'h008F, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 6'b000001);
    vecs[5]  = mk(16'h4000, 16'h4000, 1'b1, 16'h007F, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 6'b000000);
    vecs[6]  = mk(16'h4000, 16'hA000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 6'b000000);
    vecs[7]  = mk(16'h4000, 16'hA002, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 6'b010000);
    vecs[8]  = mk(16'hA000, 16'hA004, 1'b0, 16'h0000, 1'b1, 16'h0080, 1'b1, 1'b0, 1'b1, 6'b001101);
    vecs[9]  = mk(16'h4000, 16'h4000, 1'b0, 16'h0000, 1'b1, 16'h0095, 1'b0, 1'b0, 1'b1, 6'b000010);
    vecs[10] = mk(16'h4000, 16'h4000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 6'b000000);
    vecs[11] = mk(16'hA000, 16'hA004, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, GIE_RST, GIE_CAUSE);
    vecs[12] = mk(16'h4000, 16'hDFFF, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 6'b010000);
    vecs[13] = mk(16'h4000, 16'hE000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 6'b000000);
    vecs[14] = mk(16'h4000, 16'hE000, 1'b1, 16'h0080, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 6'b000001);
    vecs[15] = mk(16'hA000, 16'hA002, 1'b0, 16'h0000, 1'b1, 16'h0200, 1'b0, 1'b0, 1'b1, 6'b001000);

    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_out("reset_state", 1'b0, 6'b000000, 8'h00);

    // Table: one prep cycle to set prev_in_tcb, one stimulus cycle, then check.
    for (int i = 0; i < 16; i++) begin
      do_rst();
      drive(vecs[i].pre_pc, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
      tick();
      drive(vecs[i].pc, vecs[i].wr, vecs[i].daddr, vecs[i].dma, vecs[i].maddr,
            vecs[i].irq, vecs[i].gie);
      tick();
      idle();
      check_out($sformatf("vec%0d", i), vecs[i].exp_reset, vecs[i].exp_cause,
                vecs[i].exp_reset ? 8'h01 : 8'h00);
    end

    // Reset width: exactly four cycles, then release.
    do_rst();
    drive(16'h4000, 1'b1, 16'h0084, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    idle();
    for (int c = 0; c < 6; c++) begin
      check($sformatf("width_c%0d", c), {31'd0, bus0.reset}, (c < 4) ? 32'd1 : 32'd0);
      tick();
    end
    check_out("width_end", 1'b0, 6'b000001, 8'h01);

    // Re-violation on HOLD cycle 2: causes merge, width and count unchanged.
    do_rst();
    drive(16'h4000, 1'b1, 16'h0084, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    drive(16'h4000, 1'b1, 16'h0090, 1'b0, 16'h0000, 1'b0, 1'b0);
    check("rehold_c2", {31'd0, bus0.reset}, 32'd1);
    tick();
    idle();
    check("rehold_c3", {31'd0, bus0.reset}, 32'd1);
    tick();
    check("rehold_c4", {31'd0, bus0.reset}, 32'd1);
    tick();
    check_out("rehold_end", 1'b0, 6'b000011, 8'h01);

    // Release requires re-entry at TCB_BASE.
    drive(16'hA002, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    idle();
    check_out("reentry", 1'b1, 6'b010011, 8'h02);

    // rst mid-HOLD clears everything on the next cycle.
    do_rst();
    drive(16'h4000, 1'b1, 16'h0084, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    rst = 1'b1;
    drive(16'h4000, 1'b1, 16'h0090, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    idle();
    check_out("rst_midhold", 1'b0, 6'b000000, 8'h00);

    // Zero-size region 0 is never guarded; region 1 still is.
    do_rst();
    drive(16'h4000, 1'b1, 16'h0084, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    idle();
    check("size0_r0_reset", {31'd0, bus1.reset}, 32'd0);
    check("size0_r0_ref", {31'd0, bus0.reset}, 32'd1);
    do_rst();
    drive(16'h4000, 1'b1, 16'h0090, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    idle();
    check("size0_r1_reset", {31'd0, bus1.reset}, 32'd1);
    check("size0_r1_cause", {26'd0, bus1.viol_cause}, 32'd2);

    // Saturating count across separate episodes.
    do_rst();
    for (int e = 0; e < 260; e++) begin
      drive(16'h4000, 1'b1, 16'h0084, 1'b0, 16'h0000, 1'b0, 1'b0);
      tick();
      idle();
      for (int k = 0; k < 5; k++) tick();
      if (e == 253) check("sat_254", {24'd0, bus0.viol_count}, 32'hFE);
      if (e == 254) check("sat_255", {24'd0, bus0.viol_count}, 32'hFF);
    end
    check("sat_260", {24'd0, bus0.viol_count}, 32'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/garota_mr.md
Name: garota_mr

Overview:
- Multi-region successor to the single-UART TAROT/GAROTA monitor.
- Guards NREGIONS parametrised peripheral/memory regions against untrusted CPU and DMA writes.
- Enforces atomic, uninterruptible execution and a fixed entry point for the trusted code block (TCB).
- Drives a stretched MCU reset on any violation, and records sticky cause bits plus a saturating violation count for attestation logging.
- Sits beside the openMSP430 core, tapping pc, data bus, DMA and interrupt signals.

Parameters:
- NREGIONS, 2, number of protected regions (1..8).
- REGION_BASE, {16'h0090,16'h0080}, packed 16*NREGIONS; region i base is bits [16i+15:16i].
- REGION_SIZE, {16'h0010,16'h0010}, packed 16*NREGIONS; size 0 disables region i.
- TCB_BASE, 16'hA000, TCB start; also the only legal TCB entry address.
- TCB_SIZE, 16'h4000, TCB length in bytes.
- RESET_HOLD, 4, reset output duration in cycles (>=1).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- pc  input  16  current program counter.
- data_wr  input  1  CPU data write strobe.
- data_addr  input  16  CPU data address.
- dma_addr  input  16  DMA address.
- dma_en  input  1  DMA access active.
- irq  input  1  interrupt being serviced.
- gie  input  1  global interrupt enable.
- reset  output  1  violation reset to MCU, registered.
- viol_cause  output  NREGIONS+4  sticky cause bits.
- viol_count  output  8  saturating violation count.

Behaviour:
- Range checks:
  - addr in region i iff size_i!=0 and base_i <= addr < base_i+size_i, computed in 17 bits (no wrap).
  - pc in TCB iff TCB_BASE <= pc < TCB_BASE+TCB_SIZE, also 17-bit.
- Violation sources, evaluated combinationally each cycle:
  - v_reg[i]: (data_wr & data_addr in region i & pc not in TCB) | (dma_en & dma_addr in region i). DMA is never trusted, so the pc value does not matter for DMA.
  - v_irq: irq & pc in TCB.
  - v_dma: dma_en & pc in TCB.
  - v_entry: pc in TCB & prev_in_tcb==0 & pc!=TCB_BASE.
- prev_in_tcb is a register holding the previous cycle's "pc in TCB" result.
- viol_cause bit map:
  - [NREGIONS-1:0] = v_reg.
  - [NREGIONS] = irq.
  - [NREGIONS+1] = dma.
  - [NREGIONS+2] = entry.
  - [NREGIONS+3] = gie (see Optional Feature).
- FSM has two states, RUN and HOLD.
  - RUN, any violation: next state HOLD; reset=1 from the next cycle (1-cycle latency); hold counter loaded with RESET_HOLD-1; the violating cycle's cause bits are ORed into viol_cause; viol_count increments by 1.
  - HOLD: reset=1; counter decrements each cycle; when counter==0, the next state is RUN with reset=0. Total reset width is exactly RESET_HOLD cycles.
  - HOLD, new violation: cause bits still ORed in; counter is not reloaded; viol_count is unchanged. Only one count is added per reset episode.
  - prev_in_tcb is forced to 0 while in HOLD. The first TCB pc after release must therefore equal TCB_BASE.
- Simultaneous violations: all active cause bits are set in the same cycle; count still +1.
- viol_count saturates at 8'hFF.
- viol_cause and viol_count are cleared only by rst. They persist across violation resets.
- rst=1 (at any time, including mid-HOLD):
  - next cycle: state RUN, reset=0, counter=0, prev_in_tcb=0, viol_cause=0, viol_count=0.
  - Violations in a cycle with rst=1 are ignored.
- Reset values of all outputs are 0.

Optional Feature:
- GAROTA_GIE_LOCK_EN
- Defined: v_gie = gie & pc in TCB & prev_in_tcb, i.e. interrupts must stay disabled inside the TCB after the entry instruction. v_gie feeds viol_cause[NREGIONS+3] and the FSM like any other violation.
- Undefined: viol_cause[NREGIONS+3] is tied to 0 and gie is unused.

Test Plan:
- CPU write from untrusted code: pc=16'h4000, data_wr=1, data_addr=16'h0084 -> reset=1 on cycles 2..5 (4 cycles); viol_cause=6'b000001; viol_count=1. A write to 16'h0090 instead sets viol_cause[1].
- Trusted write and size-0 region:
  - pc=16'hA010 with prev_in_tcb=1, data_wr=1, data_addr=16'h0088 -> no reset.
  - Same write with REGION_SIZE[0]=0 and pc=16'h4000 -> no reset.
  - data_addr=16'h00A0 (just past region 1) -> no reset.
- TCB entry: pc sequence 16'h4000 -> 16'hA000 -> no violation. pc sequence 16'h4000 -> 16'hA002 -> reset, viol_cause[NREGIONS+2]=1.
- IRQ and DMA concurrent: inside TCB, irq=1 and dma_en=1 with dma_addr=16'h0080 in the same cycle -> viol_cause bits 0, NREGIONS and NREGIONS+1 all set; viol_count=1.
- Re-violation mid-HOLD, then rst:
  - Second violation on HOLD cycle 2 -> reset width still 4 cycles; count stays 1.
  - rst asserted mid-HOLD -> next cycle reset=0, viol_cause=0, viol_count=0.
- Saturation and feature:
  - 260 separate violation episodes -> viol_count=8'hFF.
  - With GAROTA_GIE_LOCK_EN: gie=1 at pc=16'hA004 after a legal entry -> reset and viol_cause[NREGIONS+3]=1.
  - Without GAROTA_GIE_LOCK_EN: same stimulus -> no reset.
